phase_sequencer: RTL and testbench
==================================

# phase_sequencer

Instruction phase sequencer for the multi-phase CPU datapath. It accepts one decoded opcode byte per instruction from the fetch stage through a valid/ready handshake. It steps through eight one-hot phase strobes, `clock_1` to `clock_8`, and holds the three 4-bit operand-select codes for the whole instruction. The register output selector directly downstream consumes `clock_3`, `clock_5` and `clock_7` together with `select_1`, `select_2` and `select_3`.

## Interface
- `PHASES`, 8: number of phase strobes. Fixed; the implementation is not required to support other values.
- `clock`, in, 1: single system clock. All state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `op_valid`, in, 1: fetch presents an opcode.
- `opcode`, in, 8: instruction opcode byte.
- `op_ready`, out, 1: sequencer accepts the opcode this cycle.
- `stall`, in, 1: freezes phase advance.
- `clock_1` … `clock_8`, out, 1 each: one-hot phase strobes.
- `select_1`, out, 4: select code for phase 3.
- `select_2`, out, 4: select code for phase 5.
- `select_3`, out, 4: select code for phase 7.
- `instr_done`, out, 1: single-cycle pulse in the last active cycle of phase 8.
- `illegal`, out, 1: single-cycle pulse when an undecodable opcode is accepted.

## Operation
- States are IDLE and P1–P8. While in Pn, `clock_n` is 1 and all other strobes are 0. In IDLE all strobes are 0.
- `op_ready` is 1 in IDLE, and in P8 when `stall` is 0. It is 0 in every other case.
- Accept means `op_valid & op_ready` at a rising edge.
- On accept, decode `opcode` into `select_1`, `select_2`, `select_3` and register them. They hold until the next accept.
- Decode table, giving `select_1`/`select_2`/`select_3`:
  - `0x90` nop: 0/0/0
  - `0x55` push ebp: 5/2/1
  - `0x5D` pop ebp: 4/2/1
  - `0xB8` mov eax,imm: 3/0/0
  - `0xE8` call: 7/2/2
  - `0xC3` ret: 4/2/2
  - `0x89` mov ebp,esp: 2/1/0
  - Any other value is illegal: selects are 0/0/0, `illegal` pulses, no phases run, and the state returns to or stays in IDLE.
- Transitions:
  - IDLE → P1 on a legal accept.
  - Pn → Pn+1 when `stall` is 0, for n < 8.
  - P8 → P1 on a legal accept. This gives back-to-back instructions with no IDLE gap.
  - P8 → IDLE when there is no accept, or when the accept is illegal.
  - Any state → itself when `stall` is 1. The strobe stays high and no accept occurs.
- `instr_done` is 1 in P8 when `stall` is 0.
- `op_ready` and `instr_done` are combinational from state and `stall`. All other outputs are registered.

## Timing
- Reset values: state IDLE, all strobes 0, all selects 0, `illegal` 0, `op_ready` 1, `instr_done` 0.
- Assertion of `reset` takes effect immediately, including mid-instruction. The in-flight instruction is abandoned and no `instr_done` is produced for it.
- Latency: an accept at edge k gives `clock_1` high in cycle k+1 and `clock_n` high in cycle k+n when there are no stalls.
- An instruction occupies exactly 8 cycles plus the number of stall cycles.
- Selects are valid from cycle k+1. They are stable through `clock_3`, `clock_5` and `clock_7`.
- `illegal` is high in the cycle after the accept edge, for exactly one cycle.
- `stall` raised in the same cycle as P8 with `op_valid`=1: no accept. The opcode must be held by fetch until `op_ready`.
- `stall` in IDLE has no effect on `op_ready`.
- No more than one strobe is high in any cycle, including the reset-release cycle.

## Test plan
- Reset release, then `0x55` presented in cycle 2:
  - `clock_1` high in cycle 3, `clock_8` high in cycle 10.
  - Selects read 5/2/1 from cycle 3.
  - `instr_done` high in cycle 10 only.
- `stall`=1 during P4 for 3 cycles:
  - `clock_4` high for 4 cycles.
  - `clock_5` follows immediately.
  - Total instruction length is 11 cycles.
- `0xE8` then `0xC3` presented back-to-back:
  - P8 of the first goes directly to P1 of the second.
  - Selects change from 7/2/2 to 4/2/2 on that edge.
  - No IDLE cycle appears.
- Opcode `0xFF` accepted from IDLE:
  - `illegal` is high for 1 cycle.
  - Strobes stay 0 and selects are 0/0/0.
  - `op_ready` stays 1.
- `reset` asserted asynchronously during P6:
  - All strobes go to 0 before the next edge.
  - Selects go to 0 and `instr_done` never pulses.
  - Sequencing restarts correctly on the next accept.
- `op_valid` held with `stall` asserted in P8:
  - No accept while the stall lasts.
  - The opcode is accepted on the first unstalled P8 cycle, followed by P1.

Source files
------------

// File: rtl/phase_sequencer.sv
// Eight-phase instruction sequencer: accepted opcode gives clock_1 one cycle later, then one strobe per unstalled cycle.
// Backpressure: op_ready only in IDLE or unstalled P8; stall freezes the current phase and blocks accepts.
module phase_sequencer #(
   parameter int PHASES = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       op_valid,
   input  logic [7:0] opcode,
   output logic       op_ready,
   input  logic       stall,
   output logic       clock_1,
   output logic       clock_2,
   output logic       clock_3,
   output logic       clock_4,
   output logic       clock_5,
   output logic       clock_6,
   output logic       clock_7,
   output logic       clock_8,
   output logic [3:0] select_1,
   output logic [3:0] select_2,
   output logic [3:0] select_3,
   output logic       instr_done,
   output logic       illegal
);

   localparam logic [3:0] IDLE = 4'd0;
   localparam logic [3:0] P1   = 4'd1;
   localparam logic [3:0] P2   = 4'd2;
   localparam logic [3:0] P3   = 4'd3;
   localparam logic [3:0] P4   = 4'd4;
   localparam logic [3:0] P5   = 4'd5;
   localparam logic [3:0] P6   = 4'd6;
   localparam logic [3:0] P7   = 4'd7;
   localparam logic [3:0] P8   = 4'd8;

   logic [3:0]        state;
   logic [3:0]        state_nxt;
   logic [PHASES-1:0] strobe;
   logic [PHASES-1:0] strobe_nxt;
   logic              dec_legal;
   logic [11:0]       dec_sel;
   logic              accept;
   logic              start;

   assign {clock_8, clock_7, clock_6, clock_5, clock_4, clock_3, clock_2, clock_1} = strobe;

   assign op_ready   = (state == IDLE) | ((state == P8) & ~stall);
   assign instr_done = (state == P8) & ~stall;
   assign accept     = op_valid & op_ready;
   assign start      = accept & dec_legal;

   // Select nibbles packed as {select_1, select_2, select_3}.
   always_comb begin
      dec_legal = 1'b1;
      dec_sel   = 12'h000;
      case (opcode)
         8'h90:   dec_sel = 12'h000;
         8'h55:   dec_sel = 12'h521;
         8'h5D:   dec_sel = 12'h421;
         8'hB8:   dec_sel = 12'h300;
         8'hE8:   dec_sel = 12'h722;
         8'hC3:   dec_sel = 12'h422;
         8'h89:   dec_sel = 12'h210;
         default: dec_legal = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:                   state_nxt = start ? P1 : IDLE;
         P1, P2, P3, P4, P5, P6, P7:
            if (!stall)          state_nxt = state + 4'd1;
         P8:
            if (!stall)          state_nxt = start ? P1 : IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // Strobes are registered alongside the state so they come straight off flops.
   always_comb begin
      strobe_nxt = '0;
      if (state_nxt != IDLE)
         strobe_nxt[3'(state_nxt - 4'd1)] = 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         strobe   <= '0;
         select_1 <= 4'd0;
         select_2 <= 4'd0;
         select_3 <= 4'd0;
         illegal  <= 1'b0;
      end else begin
         state   <= state_nxt;
         strobe  <= strobe_nxt;
         illegal <= accept & ~dec_legal;
         if (accept)
            {select_1, select_2, select_3} <= dec_sel;
      end
   end

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: behavioural phase model plus directed literal checks and randomized traffic.
module tb_phase_sequencer;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       op_valid = 1'b0;
   logic [7:0] opcode = 8'h00;
   logic       stall = 1'b0;
   logic       op_ready;
   logic       clock_1, clock_2, clock_3, clock_4, clock_5, clock_6, clock_7, clock_8;
   logic [3:0] select_1, select_2, select_3;
   logic       instr_done;
   logic       illegal;

   int total = 0;
   int bad = 0;

   phase_sequencer #(.PHASES(8)) dut (
      .clock(clock), .reset(reset), .op_valid(op_valid), .opcode(opcode),
      .op_ready(op_ready), .stall(stall),
      .clock_1(clock_1), .clock_2(clock_2), .clock_3(clock_3), .clock_4(clock_4),
      .clock_5(clock_5), .clock_6(clock_6), .clock_7(clock_7), .clock_8(clock_8),
      .select_1(select_1), .select_2(select_2), .select_3(select_3),
      .instr_done(instr_done), .illegal(illegal)
   );

   always #5 clock = ~clock;

   wire [7:0]  strobes = {clock_8, clock_7, clock_6, clock_5, clock_4, clock_3, clock_2, clock_1};
   wire [11:0] sels    = {select_1, select_2, select_3};

   // Decode table as data: opcode and its packed selects.
   logic [7:0]  tab_op  [7] = '{8'h90, 8'h55, 8'h5D, 8'hB8, 8'hE8, 8'hC3, 8'h89};
   logic [11:0] tab_sel [7] = '{12'h000, 12'h521, 12'h421, 12'h300, 12'h722, 12'h422, 12'h210};

   // Model: phase number 0 (idle) .. 8, plus held selects and the illegal pulse.
   int          m_phase;
   logic [11:0] m_sel;
   logic        m_illegal;

   task automatic lookup(input logic [7:0] op, output logic legal, output logic [11:0] sel);
      legal = 1'b0;
      sel   = 12'h000;
      for (int i = 0; i < 7; i++)
         if (tab_op[i] == op) begin
            legal = 1'b1;
            sel   = tab_sel[i];
         end
   endtask

   task automatic model_reset();
      m_phase   = 0;
      m_sel     = 12'h000;
      m_illegal = 1'b0;
   endtask

   task automatic model_edge();
      logic        ready, acc, legal;
      logic [11:0] sel;
      ready = (m_phase == 0) || (m_phase == 8 && !stall);
      acc   = op_valid && ready;
      lookup(opcode, legal, sel);
      m_illegal = acc && !legal;
      if (acc) m_sel = sel;
      if (ready)
         m_phase = (acc && legal) ? 1 : 0;
      else if (!stall)
         m_phase = m_phase + 1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
      end
   endtask

   task automatic compare_all();
      logic [7:0] exp_strobe;
      exp_strobe = (m_phase == 0) ? 8'h00 : (8'h01 << (m_phase - 1));
      chk("strobes",    32'(strobes),    32'(exp_strobe));
      chk("selects",    32'(sels),       32'(m_sel));
      chk("illegal",    32'(illegal),    32'(m_illegal));
      chk("op_ready",   32'(op_ready),   32'((m_phase == 0) || (m_phase == 8 && !stall)));
      chk("instr_done", 32'(instr_done), 32'(m_phase == 8 && !stall));
   endtask

   task automatic drive(input logic v, input logic [7:0] op, input logic st);
      op_valid = v;
      opcode   = op;
      stall    = st;
      #1;
      compare_all();
   endtask

   task automatic tick();
      @(posedge clock);
      model_edge();
      @(negedge clock);
   endtask

   task automatic step(input logic v, input logic [7:0] op, input logic st);
      drive(v, op, st);
      tick();
   endtask

   // Asynchronous reset asserted mid-cycle, held across one edge, released at a falling edge.
   task automatic async_reset();
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      chk("rst_strobes", 32'(strobes), 32'h0);
      chk("rst_selects", 32'(sels), 32'h0);
      chk("rst_done", 32'(instr_done), 32'h0);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      int c4, len;
      logic [7:0] rop;
      model_reset();
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;

      // Reset values, then 0x55 runs eight phases.
      drive(1'b0, 8'h00, 1'b0);
      chk("lit_reset_strobes", 32'(strobes), 32'h0);
      chk("lit_reset_ready", 32'(op_ready), 32'h1);
      chk("lit_reset_sel", 32'(sels), 32'h0);
      tick();
      step(1'b1, 8'h55, 1'b0);
      for (int n = 1; n <= 8; n++) begin
         drive(1'b0, 8'h00, 1'b0);
         chk("lit_55_strobe", 32'(strobes), 32'h1 << (n - 1));
         chk("lit_55_sel", 32'(sels), 32'h521);
         chk("lit_55_done", 32'(instr_done), (n == 8) ? 32'h1 : 32'h0);
         tick();
      end
      drive(1'b0, 8'h00, 1'b0);
      chk("lit_55_idle", 32'(strobes), 32'h0);
      tick();

      // Three stall cycles in P4 stretch the instruction to 11 cycles.
      step(1'b1, 8'hB8, 1'b0);
      c4 = 0;
      len = 0;
      for (int i = 1; i <= 13; i++) begin
         drive(1'b0, 8'h00, (i >= 4 && i <= 6));
         if (clock_4) c4++;
         if (strobes != 8'h00) len++;
         if (i == 8) chk("lit_stall_p5", 32'(strobes), 32'h10);
         tick();
      end
      chk("lit_stall_p4_len", 32'(c4), 32'd4);
      chk("lit_stall_total", 32'(len), 32'd11);

      // 0xE8 then 0xC3 back-to-back with no idle gap.
      step(1'b1, 8'hE8, 1'b0);
      for (int i = 1; i <= 8; i++) begin
         if (i == 8) begin
            drive(1'b1, 8'hC3, 1'b0);
            chk("lit_b2b_sel1", 32'(sels), 32'h722);
            chk("lit_b2b_ready", 32'(op_ready), 32'h1);
         end else
            drive(1'b0, 8'h00, 1'b0);
         tick();
      end
      drive(1'b0, 8'h00, 1'b0);
      chk("lit_b2b_p1", 32'(strobes), 32'h1);
      chk("lit_b2b_sel2", 32'(sels), 32'h422);
      tick();
      repeat (8) step(1'b0, 8'h00, 1'b0);

      // Illegal opcode from IDLE.
      step(1'b1, 8'hFF, 1'b0);
      drive(1'b0, 8'h00, 1'b0);
      chk("lit_ill_pulse", 32'(illegal), 32'h1);
      chk("lit_ill_strobes", 32'(strobes), 32'h0);
      chk("lit_ill_sel", 32'(sels), 32'h0);
      chk("lit_ill_ready", 32'(op_ready), 32'h1);
      tick();
      drive(1'b0, 8'h00, 1'b0);
      chk("lit_ill_once", 32'(illegal), 32'h0);
      tick();

      // Reset during P6, then restart.
      step(1'b1, 8'h5D, 1'b0);
      repeat (5) step(1'b0, 8'h00, 1'b0);
      drive(1'b0, 8'h00, 1'b0);
      chk("lit_rst_p6", 32'(strobes), 32'h20);
      async_reset();
      repeat (3) step(1'b0, 8'h00, 1'b0);
      step(1'b1, 8'h55, 1'b0);
      drive(1'b0, 8'h00, 1'b0);
      chk("lit_restart_p1", 32'(strobes), 32'h1);
      chk("lit_restart_sel", 32'(sels), 32'h521);
      tick();
      repeat (8) step(1'b0, 8'h00, 1'b0);

      // op_valid held while P8 is stalled.
      step(1'b1, 8'h90, 1'b0);
      repeat (7) step(1'b0, 8'h00, 1'b0);
      drive(1'b1, 8'h89, 1'b1);
      chk("lit_p8stall_ready", 32'(op_ready), 32'h0);
      tick();
      drive(1'b1, 8'h89, 1'b1);
      chk("lit_p8stall_hold", 32'(strobes), 32'h80);
      tick();
      drive(1'b1, 8'h89, 1'b0);
      chk("lit_p8_ready", 32'(op_ready), 32'h1);
      chk("lit_p8_oldsel", 32'(sels), 32'h000);
      tick();
      drive(1'b0, 8'h00, 1'b0);
      chk("lit_p8_next_p1", 32'(strobes), 32'h1);
      chk("lit_p8_newsel", 32'(sels), 32'h210);
      tick();

      // Randomized traffic against the model, with occasional async resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) < 7)
            rop = tab_op[$urandom_range(0, 6)];
         else
            rop = 8'($urandom_range(0, 255));
         drive(($urandom_range(0, 2) != 0), rop, ($urandom_range(0, 3) == 0));
         if ($urandom_range(0, 299) == 0)
            async_reset();
         else
            tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
